// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared types and helpers for param_register_file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_SWEEP = 1'b1
    } rf_state_t;

    // Widest entry the parity helper handles; narrower data is zero-extended,
    // which leaves the XOR reduction unchanged.
    localparam int PARITY_MAX_W = 1024;

    function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
        return ^data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_clear_sequencer.sv
// ============================================================================
// Module      : regfile_clear_sequencer
// Description : Sweeps every register-file entry to zero, one per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_clear_sequencer
    import regfile_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              ClearRequest,
    output logic              Busy,
    output logic              ClearDone,
    output logic              SweepEnable,
    output logic [ADDR_W-1:0] SweepIndex
);

    localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(DEPTH - 1);

    rf_state_t         state;
    rf_state_t         state_next;
    logic [ADDR_W-1:0] index;
    logic [ADDR_W-1:0] index_next;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state <= RF_IDLE;
            index <= '0;
        end else begin
            state <= state_next;
            index <= index_next;
        end
    end

    always_comb begin
        state_next  = state;
        index_next  = index;
        Busy        = 1'b0;
        ClearDone   = 1'b0;
        SweepEnable = 1'b0;
        case (state)
            RF_IDLE: begin
                if (ClearRequest) begin
                    state_next = RF_SWEEP;
                    index_next = '0;
                end
            end
            RF_SWEEP: begin
                Busy        = 1'b1;
                SweepEnable = 1'b1;
                // The last entry is cleared in the same cycle the done pulse fires.
                if (index == LAST_INDEX) begin
                    ClearDone  = 1'b1;
                    state_next = RF_IDLE;
                    index_next = '0;
                end else begin
                    index_next = index + 1'b1;
                end
            end
            default: begin
                state_next = RF_IDLE;
                index_next = '0;
            end
        endcase
    end

    assign SweepIndex = index;

endmodule

`default_nettype wire

// File: rtl/param_register_file.sv
// ============================================================================
// Module      : param_register_file
// Description : 1W/2R register file with bypass, zero entry and clear sweep.
//               Optional parity storage enabled by macro REGFILE_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 64,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter bit BYPASS   = 1'b1,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              WriteEnable,
    input  logic [ADDR_W-1:0] WriteAddress,
    input  logic [DATA_W-1:0] WriteData,
    output logic              WriteReady,
    input  logic [ADDR_W-1:0] ReadAddressA,
    input  logic [ADDR_W-1:0] ReadAddressB,
    output logic [DATA_W-1:0] ReadDataA,
    output logic [DATA_W-1:0] ReadDataB,
    input  logic              ClearRequest,
    output logic              Busy,
    output logic              ClearDone
`ifdef REGFILE_PARITY_EN
    ,
    input  logic              ParityInject,
    output logic              ParityErrorA,
    output logic              ParityErrorB
`endif
);

    logic [DATA_W-1:0]         mem [DEPTH];
    logic                      busy;
    logic                      sweep_en;
    logic [ADDR_W-1:0]         sweep_idx;
    logic                      write_accept;
    logic [1:0][ADDR_W-1:0]    rd_addr;
    logic [1:0][DATA_W-1:0]    rd_data;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr} < (ADDR_W + 1)'(DEPTH);
    endfunction

    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return ZERO_REG && (addr == '0);
    endfunction

    regfile_clear_sequencer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_sequencer (
        .Clock        (Clock),
        .nReset       (nReset),
        .ClearRequest (ClearRequest),
        .Busy         (busy),
        .ClearDone    (ClearDone),
        .SweepEnable  (sweep_en),
        .SweepIndex   (sweep_idx)
    );

    assign Busy       = busy;
    assign WriteReady = ~busy;

    // External writes are impossible while sweeping because WriteReady is low.
    assign write_accept = WriteEnable && WriteReady && in_range(WriteAddress)
                          && !is_zero_reg(WriteAddress);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (sweep_en) begin
            mem[sweep_idx] <= '0;
        end else if (write_accept) begin
            mem[WriteAddress] <= WriteData;
        end
    end

`ifdef REGFILE_PARITY_EN
    logic       par [DEPTH];
    logic [1:0] rd_perr;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < DEPTH; i++) begin
                par[i] <= 1'b0;
            end
        end else if (sweep_en) begin
            par[sweep_idx] <= 1'b0;
        end else if (write_accept) begin
            par[WriteAddress] <= even_parity(PARITY_MAX_W'(WriteData)) ^ ParityInject;
        end
    end

    assign ParityErrorA = rd_perr[0];
    assign ParityErrorB = rd_perr[1];
`endif

    assign rd_addr[0] = ReadAddressA;
    assign rd_addr[1] = ReadAddressB;

    for (genvar p = 0; p < 2; p++) begin : g_read_port
        logic valid;
        logic hit;

        assign valid      = in_range(rd_addr[p]) && !is_zero_reg(rd_addr[p]);
        assign hit        = BYPASS && write_accept && (rd_addr[p] == WriteAddress);
        assign rd_data[p] = valid ? (hit ? WriteData : mem[rd_addr[p]]) : '0;
`ifdef REGFILE_PARITY_EN
        assign rd_perr[p] = (valid && !hit) ? ((^mem[rd_addr[p]]) ^ par[rd_addr[p]]) : 1'b0;
`endif
    end

    assign ReadDataA = rd_data[0];
    assign ReadDataB = rd_data[1];

endmodule

`default_nettype wire
